fft_bitrev_reorder: RTL and testbench
=====================================

# fft_bitrev_reorder

Frame reorder buffer sitting directly upstream of the first FFT stage in the accelerator tile. It accepts complex samples in natural order over a decoupled valid/ready stream and re-emits each frame of `number_points` samples in bit-reversed index order, which is the input ordering the radix-2 stage chain requires. A two-bank ping-pong store lets one frame fill while the previous frame drains, so sustained throughput is one sample per cycle in each direction.

## Interface
- `number_points`, default 64: samples per frame. Must be a power of two and at least 2; `LOG2 = $clog2(number_points)`.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `acc_config`  in  `acc_pkg::acc_config_t`  uncached configuration. Unused by this block; present for uniform stage wiring.
- `reverse_en`  in  1  1 selects bit-reversed drain order, 0 selects natural-order pass-through. Latched per bank on the first write of a frame.
- `consumer_data`  `decoupled_vr_if.slave`  64  input stream; data[31:0] is real, data[63:32] is imaginary.
- `producer_data`  `decoupled_vr_if.master`  64  output stream, same packing; feeds the FFT stage-0 consumer port.

## Operation
- State:
  - two banks `mem[2][number_points]` of 64 bits each, not reset;
  - `full[1:0]`;
  - `wr_bank`, `rd_bank` (1 bit each);
  - `wr_cnt`, `rd_cnt` (`LOG2` bits each);
  - `rev[1:0]`.
- `consumer_data.ready = ~full[wr_bank]`.
- Write handshake (valid & ready):
  - `mem[wr_bank][wr_cnt] <= data`.
  - If `wr_cnt == 0`, also `rev[wr_bank] <= reverse_en`.
  - If `wr_cnt == number_points-1`: `full[wr_bank] <= 1`, `wr_bank` toggles, `wr_cnt <= 0`.
  - Otherwise `wr_cnt` increments.
- `producer_data.valid = full[rd_bank]`.
- `producer_data.data = mem[rd_bank][idx]`, where `idx = rev[rd_bank] ? bitrev(rd_cnt) : rd_cnt`. The output is forced to 0 when valid is low.
  - `bitrev` mirrors the `LOG2` bits of the count: bit k maps to bit `LOG2-1-k`.
- Read handshake:
  - If `rd_cnt == number_points-1`: `full[rd_bank] <= 0`, `rd_bank` toggles, `rd_cnt <= 0`.
  - Otherwise `rd_cnt` increments.
- Simultaneous write-last and read-last in the same cycle: these always target different banks, and both updates take effect.
- A write to a bank and a read from the same bank in the same cycle cannot occur. Write requires `~full[wr_bank]`, read requires `full[rd_bank]`, and `wr_bank == rd_bank` implies at most one of those holds.
- Both banks full: ready is 0 until the next read-last frees a bank.
- Both banks empty: valid is 0.
- `reverse_en` changes mid-frame do not affect the frame in flight.
- Data is passed unmodified; there is no arithmetic on sample values.

## Timing
- Reset values (asynchronous): `full = 0`, `wr_bank = rd_bank = 0`, `wr_cnt = rd_cnt = 0`, `rev = 0`.
  - Resulting outputs: `producer_data.valid = 0`, `producer_data.data = 0`, `consumer_data.ready = 1`.
- Latency: the first output of a frame is valid in the cycle after the write handshake of that frame's last sample.
  - Fill-to-first-output is `number_points` cycles at full input rate.
- Output is combinational from registered state and memory; `ready` is not combinationally dependent on `producer_data.ready`.
- Sustained rate: 1 sample/cycle in and out with no bubbles at frame boundaries while both sides are streaming.
- Valid/ready rules:
  - Once asserted, `producer_data.valid` and `data` remain stable until the handshake.
  - Input may be stalled arbitrarily with no loss.
- Reset mid-frame discards all buffered data. The frame restarts from `wr_cnt = 0`, and no partial output is emitted.

## Test plan
- Single frame, reverse: N=64, `reverse_en=1`, input `data = i` for i=0..63, producer ready held high.
  - Outputs are 0, 32, 16, 48, 8, 40, … and the final sample is 63.
  - The first output is valid exactly 1 cycle after the 64th input handshake.
- Pass-through and latch: `reverse_en=0` for frame A (i=0..63), toggled to 1 at input 10 of frame B.
  - A drains as 0..63 in order.
  - B drains in natural order, because `rev` was latched at B's first write.
- Back-to-back streaming: 4 frames sent continuously, producer ready always high.
  - Input ready never drops after reset.
  - 256 outputs occur with no idle cycles between frames after the first fill.
- Full backpressure: producer ready held 0 while sending 200 samples.
  - Exactly 128 are accepted, then `consumer_data.ready = 0`.
  - After ready is raised, 64 outputs are produced before ready returns to 1.
- Random stalls: random valid and ready, 20 frames with `data = {frame, idx}` and random `reverse_en`.
  - Scoreboard ordering matches the bit-reverse/natural order of each frame.
  - Valid and data hold stable across stalls.
- Reset mid-operation: assert `rst_n=0` after 37 inputs and again mid-drain.
  - Valid goes to 0 asynchronously and ready goes to 1.
  - The next full frame is output correctly with no stale samples.

Source files
------------

// File: rtl/fft_bitrev_reorder.sv
// rtl/fft_bitrev_reorder.sv - ping-pong frame buffer emitting natural or bit-reversed sample order
//
// Purpose: buffers frames of number_points complex samples (64-bit, imag[63:32],
// real[31:0]) and re-emits each frame in bit-reversed index order (or natural
// order) ahead of the first radix-2 FFT stage. Two banks let one frame fill
// while the other drains, sustaining one sample per cycle in each direction.
//
// Ports:
//   clk                    clock, rising edge
//   rst_n                  asynchronous active-low reset
//   acc_config_i           tile configuration, not used by this stage
//   reverse_en_i           1: bit-reversed drain, 0: natural order; latched per frame
//   consumer_data_valid_i  input stream valid
//   consumer_data_data_i   input stream sample
//   consumer_data_ready_o  input stream ready
//   producer_data_valid_o  output stream valid
//   producer_data_data_o   output stream sample, 0 while valid is low
//   producer_data_ready_i  output stream ready

package acc_pkg;
    typedef struct packed {
        logic [31:0] base_addr;
        logic [15:0] frame_len;
        logic [7:0]  mode;
    } acc_config_t;
endpackage

module fft_bitrev_reorder #(
    parameter  int number_points = 64,
    localparam int LOG2          = $clog2(number_points)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  acc_pkg::acc_config_t acc_config_i,
    input  logic                 reverse_en_i,
    input  logic                 consumer_data_valid_i,
    input  logic [63:0]          consumer_data_data_i,
    output logic                 consumer_data_ready_o,
    output logic                 producer_data_valid_o,
    output logic [63:0]          producer_data_data_o,
    input  logic                 producer_data_ready_i
);
    localparam logic [LOG2-1:0] LAST = LOG2'(number_points - 1);

    logic [63:0]     mem_q [2][number_points];
    logic [1:0]      full_q, full_d;
    logic [1:0]      rev_q, rev_d;
    logic            wr_bank_q, wr_bank_d;
    logic            rd_bank_q, rd_bank_d;
    logic [LOG2-1:0] wr_cnt_q, wr_cnt_d;
    logic [LOG2-1:0] rd_cnt_q, rd_cnt_d;
    logic [LOG2-1:0] rd_idx;
    logic            wr_fire, rd_fire;
    logic            unused_cfg;

    assign unused_cfg = ^acc_config_i;

    function automatic logic [LOG2-1:0] bitrev(input logic [LOG2-1:0] v);
        logic [LOG2-1:0] r;
        r = '0;
        for (int k = 0; k < LOG2; k++) begin
            r[LOG2-1-k] = v[k];
        end
        return r;
    endfunction

    // The writer and reader can only share a bank when exactly one of these
    // holds, so a bank is never written and read in the same cycle.
    assign consumer_data_ready_o = ~full_q[wr_bank_q];
    assign producer_data_valid_o = full_q[rd_bank_q];
    assign wr_fire = consumer_data_valid_i & consumer_data_ready_o;
    assign rd_fire = producer_data_valid_o & producer_data_ready_i;

    assign rd_idx = rev_q[rd_bank_q] ? bitrev(rd_cnt_q) : rd_cnt_q;
    assign producer_data_data_o = producer_data_valid_o ? mem_q[rd_bank_q][rd_idx] : 64'd0;

    always_comb begin
        full_d    = full_q;
        rev_d     = rev_q;
        wr_bank_d = wr_bank_q;
        rd_bank_d = rd_bank_q;
        wr_cnt_d  = wr_cnt_q;
        rd_cnt_d  = rd_cnt_q;

        if (wr_fire) begin
            // Drain order is captured with the first sample so mid-frame
            // changes on reverse_en_i only apply to the next frame.
            if (wr_cnt_q == '0) begin
                rev_d[wr_bank_q] = reverse_en_i;
            end
            if (wr_cnt_q == LAST) begin
                full_d[wr_bank_q] = 1'b1;
                wr_bank_d         = ~wr_bank_q;
                wr_cnt_d          = '0;
            end else begin
                wr_cnt_d = wr_cnt_q + LOG2'(1);
            end
        end

        // Write-last and read-last in one cycle touch different banks, so
        // both bit updates below coexist.
        if (rd_fire) begin
            if (rd_cnt_q == LAST) begin
                full_d[rd_bank_q] = 1'b0;
                rd_bank_d         = ~rd_bank_q;
                rd_cnt_d          = '0;
            end else begin
                rd_cnt_d = rd_cnt_q + LOG2'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q    <= '0;
            rev_q     <= '0;
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            wr_cnt_q  <= '0;
            rd_cnt_q  <= '0;
        end else begin
            full_q    <= full_d;
            rev_q     <= rev_d;
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
            wr_cnt_q  <= wr_cnt_d;
            rd_cnt_q  <= rd_cnt_d;
        end
    end

    // Sample storage carries no reset; stale contents are unreachable
    // because a bank is only read after it has been completely refilled.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem_q[wr_bank_q][wr_cnt_q] <= consumer_data_data_i;
        end
    end

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// tb/tb_fft_bitrev_reorder.sv - scoreboard bench for fft_bitrev_reorder
module tb_fft_bitrev_reorder;
    localparam int N  = 64;
    localparam int LG = 6;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b1;
    acc_pkg::acc_config_t acc_config;
    logic                 reverse_en;
    logic                 in_valid, in_ready, out_valid, out_ready;
    logic [63:0]          in_data, out_data;

    always #5 clk = ~clk;

    fft_bitrev_reorder #(.number_points(N)) dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .acc_config_i          (acc_config),
        .reverse_en_i          (reverse_en),
        .consumer_data_valid_i (in_valid),
        .consumer_data_data_i  (in_data),
        .consumer_data_ready_o (in_ready),
        .producer_data_valid_o (out_valid),
        .producer_data_data_o  (out_data),
        .producer_data_ready_i (out_ready)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic [63:0] sb[$];
    logic [63:0] olog[$];
    logic [63:0] fr [N];
    int          wcnt = 0;
    bit          frev = 1'b0;
    int          cyc = 0;
    int          last_fill_cyc = -1, first_out_cyc = -1, last_out_cyc = -1;
    int          out_fires = 0, ready_drops = 0;
    bit          s_in_fire, s_out_fire, s_in_ready;
    bit          prev_stall = 1'b0;
    logic [63:0] prev_data;
    int          rdy_prob = 100;

    function automatic int bitrev6(input int v);
        int r;
        r = 0;
        for (int k = 0; k < LG; k++) begin
            if (((v >> k) & 1) != 0) r = r | (1 << (LG - 1 - k));
        end
        return r;
    endfunction

    // One clock: observe at the falling edge, update model, return just after the rising edge.
    task automatic tick();
        @(negedge clk);
        cyc++;
        s_in_ready = in_ready;
        s_in_fire  = in_valid && in_ready;
        s_out_fire = out_valid && out_ready;
        if (prev_stall) begin
            check_eq("hold_valid", 64'(out_valid), 64'd1);
            check_eq("hold_data", out_data, prev_data);
        end
        prev_stall = out_valid && !out_ready;
        prev_data  = out_data;
        if (in_valid && !in_ready) ready_drops++;
        if (out_valid && first_out_cyc < 0) first_out_cyc = cyc;
        if (s_out_fire) begin
            out_fires++;
            last_out_cyc = cyc;
            olog.push_back(out_data);
            if (sb.size() == 0) check_eq("sb_underflow", 64'(sb.size()), 64'd1);
            else check_eq("sb_data", out_data, sb.pop_front());
        end
        if (s_in_fire) begin
            if (wcnt == 0) frev = reverse_en;
            fr[wcnt] = in_data;
            if (wcnt == N - 1) begin
                last_fill_cyc = cyc;
                for (int k = 0; k < N; k++) sb.push_back(fr[frev ? bitrev6(k) : k]);
                wcnt = 0;
            end else begin
                wcnt++;
            end
        end
        @(posedge clk);
        #1;
        out_ready = ($urandom_range(99) < rdy_prob);
    endtask

    task automatic send_one(input logic [63:0] d, input logic rev, input int gap_pct);
        while ($urandom_range(99) < gap_pct) begin
            in_valid = 1'b0;
            tick();
        end
        in_valid   = 1'b1;
        in_data    = d;
        reverse_en = rev;
        for (int t = 0; t < 2000; t++) begin
            tick();
            if (s_in_fire) return;
        end
        check_eq("send_timeout", 64'd0, 64'd1);
    endtask

    task automatic drain();
        in_valid = 1'b0;
        for (int t = 0; t < 5000; t++) begin
            if (sb.size() == 0) break;
            tick();
        end
        check_eq("drained", 64'(sb.size()), 64'd0);
        check_eq("idle_valid", 64'(out_valid), 64'd0);
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        check_eq("rst_valid", 64'(out_valid), 64'd0);
        check_eq("rst_data", out_data, 64'd0);
        check_eq("rst_ready", 64'(in_ready), 64'd1);
        sb.delete();
        wcnt       = 0;
        prev_stall = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int k;
        int n;
        acc_config = '0;
        in_valid   = 1'b0;
        in_data    = '0;
        reverse_en = 1'b0;
        out_ready  = 1'b1;
        #2;
        do_reset();

        // Single frame, bit-reversed, with latency check
        olog.delete();
        first_out_cyc = -1;
        for (int i = 0; i < N; i++) send_one(64'(i), 1'b1, 0);
        drain();
        check_eq("t1_latency", 64'(first_out_cyc - last_fill_cyc), 64'd1);
        check_eq("t1_count", 64'(olog.size()), 64'd64);
        if (olog.size() == 64) begin
            check_eq("t1_o0", olog[0], 64'd0);
            check_eq("t1_o1", olog[1], 64'd32);
            check_eq("t1_o2", olog[2], 64'd16);
            check_eq("t1_o3", olog[3], 64'd48);
            check_eq("t1_o4", olog[4], 64'd8);
            check_eq("t1_o5", olog[5], 64'd40);
            check_eq("t1_o63", olog[63], 64'd63);
        end

        // Natural order, reverse_en raised mid-frame B
        olog.delete();
        for (int i = 0; i < 2 * N; i++) send_one({32'(i / N), 32'(i % N)}, (i >= N + 10), 0);
        drain();
        check_eq("t2_count", 64'(olog.size()), 64'd128);
        if (olog.size() == 128) begin
            check_eq("t2_a1", olog[1], 64'd1);
            check_eq("t2_a63", olog[63], 64'd63);
            check_eq("t2_b1", olog[65], {32'd1, 32'd1});
            check_eq("t2_b2", olog[66], {32'd1, 32'd2});
            check_eq("t2_b63", olog[127], {32'd1, 32'd63});
        end

        // Back-to-back streaming, four frames
        ready_drops   = 0;
        out_fires     = 0;
        first_out_cyc = -1;
        for (int i = 0; i < 4 * N; i++) send_one({32'(i / N), 32'(i % N)}, 1'($urandom_range(1)), 0);
        drain();
        check_eq("t3_ready_drops", 64'(ready_drops), 64'd0);
        check_eq("t3_out_count", 64'(out_fires), 64'd256);
        check_eq("t3_out_span", 64'(last_out_cyc - first_out_cyc + 1), 64'd256);

        // Full backpressure
        rdy_prob   = 0;
        out_ready  = 1'b0;
        k          = 0;
        in_valid   = 1'b1;
        reverse_en = 1'b1;
        for (int t = 0; t < 200; t++) begin
            in_data = {32'd2, 32'(k)};
            tick();
            if (s_in_fire) k++;
        end
        check_eq("t4_accepted", 64'(k), 64'd128);
        check_eq("t4_ready_low", 64'(in_ready), 64'd0);
        in_valid  = 1'b0;
        rdy_prob  = 100;
        out_ready = 1'b1;
        n         = 0;
        for (int t = 0; t < 500; t++) begin
            tick();
            if (s_in_ready) break;
            if (s_out_fire) n++;
        end
        check_eq("t4_outs_to_ready", 64'(n), 64'd64);
        drain();

        // Random stalls on both sides, random per-sample reverse_en
        rdy_prob = 60;
        for (int f = 0; f < 20; f++) begin
            for (int i = 0; i < N; i++) send_one({32'(f), 32'(i)}, 1'($urandom_range(1)), 30);
        end
        drain();

        // Reset mid-fill with a full bank waiting, then mid-drain
        rdy_prob  = 0;
        out_ready = 1'b0;
        for (int i = 0; i < N + 37; i++) send_one({32'd3, 32'(i)}, 1'b1, 0);
        check_eq("t6_pre_valid", 64'(out_valid), 64'd1);
        do_reset();
        rdy_prob  = 100;
        out_ready = 1'b1;
        for (int i = 0; i < N; i++) send_one({32'd4, 32'(i)}, 1'b1, 0);
        in_valid = 1'b0;
        for (int t = 0; t < 20; t++) tick();
        check_eq("t6_mid_valid", 64'(out_valid), 64'd1);
        do_reset();
        olog.delete();
        for (int i = 0; i < N; i++) send_one({32'd5, 32'(i)}, 1'b0, 0);
        drain();
        check_eq("t6_count", 64'(olog.size()), 64'd64);
        if (olog.size() == 64) begin
            check_eq("t6_o0", olog[0], {32'd5, 32'd0});
            check_eq("t6_o63", olog[63], {32'd5, 32'd63});
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
